uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, valid/ready input handshake, configurable data and stop bits, and optional runtime-selectable parity. It is the next-generation transmit path of the test harness serial link. Upstream logic streams bytes without waiting on each frame, and frames leave back-to-back with no idle gap while data is queued.

## Interface
- DATA_BITS, 8, data bits per frame, 5..9
- STOP_BITS, 1, stop bits per frame, 1..2
- CLKS_PER_BIT, 1000, clocks per serial bit, ≥2
- FIFO_DEPTH, 4, FIFO entries, power of two, ≥2
- clk  in  1  system clock; one clock domain, all logic on rising edge
- n_reset  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data is valid
- in_ready  out  1  FIFO can accept a word (not full)
- in_data  in  DATA_BITS  word to transmit, LSB sent first
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark; sampled with in_data
- fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries
- busy  out  1  frame in progress, or FIFO non-empty
- out  out  1  serial line, idle high

## Operation
- Push occurs on a clock edge with in_valid && in_ready. Each entry stores in_data and parity_mode.
- in_ready = (fifo_level != FIFO_DEPTH). There is no bypass when full: a push and a pop in the same cycle while full are not possible.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: out=1. Pop when the FIFO is non-empty, load the shift register and parity mode, clear the bit and baud counters, go to START.
  - START: out=0 for one bit time, then go to DATA.
  - DATA: out=shift[0]. Shift right each bit time. After DATA_BITS bits, go to PARITY if mode≠00 (and parity is compiled in), else go to STOP.
  - PARITY: out = XOR of the data (even), its inverse (odd), or 1 (mark). One bit time, then go to STOP.
  - STOP: out=1 for STOP_BITS bit times. At the end, if the FIFO is non-empty, pop and go directly to START; else go to IDLE.
- The baud counter restarts at each frame start. Every bit lasts exactly CLKS_PER_BIT cycles, and there is no sync wait against a free-running tick.
- Counter widths: baud counter $clog2(CLKS_PER_BIT); bit counter $clog2(DATA_BITS+1). Counters wrap only by explicit clear.
- busy = (state≠IDLE) || (fifo_level≠0).
- Reset asserted mid-frame: the frame is abandoned and the line returns high immediately.

## Timing
- Reset values: out=1, in_ready=1, fifo_level=0, busy=0, state IDLE, FIFO pointers 0.
- Push at edge N into an empty FIFO while IDLE:
  - fifo_level=1 after N.
  - Pop at edge N+1; out=0 from N+1.
  - fifo_level returns to 0 after N+1.
- Frame length is (1+DATA_BITS+P+STOP_BITS)×CLKS_PER_BIT cycles, where P=1 if parity is active.
- Back-to-back: the last stop-bit cycle is followed immediately by the next start bit (0 idle cycles).
- Push and pop in the same cycle when not full: fifo_level is unchanged and both operations complete.
- Pointer wrap-around at FIFO_DEPTH is modulo; full/empty are derived from an extra pointer MSB.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state, parity storage in the FIFO, and parity_mode decoding are present.
- UART_TX_PARITY_EN undefined:
  - The parity_mode port remains but is ignored.
  - No parity bits are stored and the PARITY state is never entered.
  - Frames are always START+DATA+STOP.

## Structure
- Shared package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - parity_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK)
  - width helper functions
- Sub-module sync_fifo: parametrised width/depth, push/pop, full/empty/level.
- The top level contains the FSM, baud and bit counters, shift register, and output mux.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4 unless noted.
- Single byte: push 0xA5, mode 00 → out=0 for 4 cycles, then 1,0,1,0,0,1,0,1 each for 4 cycles, then 1 for 4 cycles. Total 40 cycles; busy drops after the frame.
- Parity: push 0xA5 with mode 01 → parity bit 0; with mode 10 → 1; with mode 11 → 1. Frame is 44 cycles. With the macro undefined → 40 cycles.
- Back-to-back: push 0x00, 0xFF, 0x3C in consecutive cycles → 120 contiguous frame cycles, with no high gap between the stop bit and the next start bit.
- Full: push 5 words while frame 1 is in progress → in_ready=0 with fifo_level=4. The 5th word is held by in_valid and accepted when the stop bit of frame 1 completes.
- Reset mid-frame: assert n_reset during a DATA bit with 2 words queued → out=1, fifo_level=0, in_ready=1, busy=0 asynchronously. The next push transmits normally.
- STOP_BITS=2: push 0x81 → stop high for 8 cycles; total 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and width helpers for the UART transmit path.
// Optional parity support is enabled with the UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD,
    PAR_MARK
  } parity_mode_t;

  // Counter width for a counter running 0..n-1, never narrower than 1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of an occupancy count 0..depth.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Parity line value given the XOR of the data bits.
  function automatic logic par_bit(input parity_mode_t m,
                                   input logic x);
    logic r;
    r = 1'b0;
    case (m)
      PAR_EVEN: r = x;
      PAR_ODD:  r = ~x;
      PAR_MARK: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers.
// Full/empty come from pointer compare; level is their difference.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int AW = cnt_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer advance; wrap is modulo through natural overflow.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = LW'(wr_ptr - rd_ptr);

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter, back-to-back frames.
// Define UART_TX_PARITY_EN to add per-word runtime parity.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic [1:0]                    parity_mode,
  output logic [lvl_w(FIFO_DEPTH)-1:0]  fifo_level,
  output logic                          busy,
  output logic                          out
);

  localparam int BW = cnt_w(CLKS_PER_BIT);
  localparam int CW = cnt_w(DATA_BITS + 1);
`ifdef UART_TX_PARITY_EN
  localparam int FW = DATA_BITS + 2;
`else
  localparam int FW = DATA_BITS;
`endif

  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  tx_state_t            state, state_n;
  logic [BW-1:0]        baud, baud_n;
  logic [CW-1:0]        bitc, bitc_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 bit_end;
  logic                 load;
  logic                 pop;
  logic                 push;
  logic                 full;
  logic                 empty;
  logic [FW-1:0]        wdata;
  logic [FW-1:0]        rdata;
  logic [DATA_BITS-1:0] rd_word;

`ifdef UART_TX_PARITY_EN
  parity_mode_t         pmode, pmode_n;
  logic                 pbit, pbit_n;
  parity_mode_t         rd_mode;

  assign wdata   = {parity_mode, in_data};
  assign rd_mode = parity_mode_t'(rdata[FW-1 -: 2]);
`else
  logic                 unused_par;

  assign wdata      = in_data;
  assign unused_par = ^parity_mode;
`endif

  assign rd_word  = rdata[DATA_BITS-1:0];
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign bit_end  = (baud == BAUD_MAX);
  assign busy     = (state != IDLE) || !empty;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (push),
    .pop     (pop),
    .wdata   (wdata),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // State and datapath registers; reset abandons any frame.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      baud  <= '0;
      bitc  <= '0;
      shift <= '0;
`ifdef UART_TX_PARITY_EN
      pmode <= PAR_NONE;
      pbit  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      baud  <= baud_n;
      bitc  <= bitc_n;
      shift <= shift_n;
`ifdef UART_TX_PARITY_EN
      pmode <= pmode_n;
      pbit  <= pbit_n;
`endif
    end
  end

  // Next state, counters, line value, and frame (re)load.
  always_comb begin
    state_n = state;
    baud_n  = bit_end ? '0 : baud + 1'b1;
    bitc_n  = bitc;
    shift_n = shift;
    load    = 1'b0;
    pop     = 1'b0;
    out     = 1'b1;
`ifdef UART_TX_PARITY_EN
    pmode_n = pmode;
    pbit_n  = pbit;
`endif
    unique case (state)
      IDLE: begin
        baud_n = '0;
        load   = !empty;
      end
      START: begin
        out = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        out = shift[0];
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bitc == DATA_LAST) begin
            bitc_n  = '0;
`ifdef UART_TX_PARITY_EN
            state_n = (pmode != PAR_NONE) ? PARITY : STOP;
`else
            state_n = STOP;
`endif
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        out = pbit;
        if (bit_end) state_n = STOP;
`else
        state_n = IDLE;
`endif
      end
      STOP: begin
        if (bit_end) begin
          if (bitc == STOP_LAST) begin
            bitc_n  = '0;
            state_n = IDLE;
            load    = !empty;
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      pop     = 1'b1;
      state_n = START;
      baud_n  = '0;
      bitc_n  = '0;
      shift_n = rd_word;
`ifdef UART_TX_PARITY_EN
      pmode_n = rd_mode;
      pbit_n  = par_bit(rd_mode, ^rd_word);
`endif
    end
  end

endmodule
